// File: rtl/sd_reg_seq_arbiter.sv
// Purpose : round-robin arbiter for two 32-bit word requesters, serializing each word
//           onto the byte-wide SD register port, MS byte first so byte 0 is written last.
// Latency : accept at T, byte cycles T+1..T+4 (byte 3 first), resp pulse at T+5, next accept T+6.
// Backpr. : reqN_ready only in IDLE for the granted requester; a request not granted simply waits.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid/we/addr/wdata/be   word request from requester N (addr[1:0] ignored)
//   reqN_ready                    combinational accept strobe (valid && ready = taken)
//   respN_valid/rdata             one-cycle completion pulse, read data (0 for writes)
//   reg_we/addr/wdata             registered byte port towards the register block
//   reg_rdata                     combinational read byte for reg_addr
//   busy                          high while a word is being transferred or answered
module sd_reg_seq_arbiter (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0_valid,
   input  logic        req0_we,
   input  logic [6:0]  req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic [3:0]  req0_be,
   output logic        req0_ready,
   output logic        resp0_valid,
   output logic [31:0] resp0_rdata,

   input  logic        req1_valid,
   input  logic        req1_we,
   input  logic [6:0]  req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic [3:0]  req1_be,
   output logic        req1_ready,
   output logic        resp1_valid,
   output logic [31:0] resp1_rdata,

   output logic        reg_we,
   output logic [6:0]  reg_addr,
   output logic [7:0]  reg_wdata,
   input  logic [7:0]  reg_rdata,

   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   // Latched copy of the accepted request; the word address drops the byte bits.
   typedef struct packed {
      logic        we;
      logic [4:0]  word;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   state_t      state;
   state_t      state_nxt;

   logic        last_grant;
   logic        grant;
   logic        accept;
   logic        owner;
   logic [1:0]  byte_idx;
   logic [31:0] rdata;
   req_t        sel_req;
   req_t        lat_req;

   // Next values for the registered byte port.
   logic [1:0]  nxt_idx;
   logic        nxt_we;
   logic [6:0]  nxt_addr;
   logic [7:0]  nxt_wdata;

   // Word-aligned addressing: the byte bits of the request address carry no meaning.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{req0_addr[1:0], req1_addr[1:0]};

   // ------------------------------------------------------------------
   // Arbitration: on contention the requester not served last wins.
   // last_grant resets to 1 so req0 wins the first contention.
   // ------------------------------------------------------------------
   always_comb begin
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else begin
         grant = ~req0_valid;
      end
      // Reset gating keeps ready low while rst is held.
      accept = (state == IDLE) && (req0_valid || req1_valid) && !rst;

      sel_req.we    = grant ? req1_we         : req0_we;
      sel_req.word  = grant ? req1_addr[6:2]  : req0_addr[6:2];
      sel_req.wdata = grant ? req1_wdata      : req0_wdata;
      sel_req.be    = grant ? req1_be         : req0_be;
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = XFER;
         XFER:    if (byte_idx == 2'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs, plus the byte to present on the register port in the
   // next cycle. The port itself is registered, so the byte-3 values are
   // prepared from the incoming request in the accept cycle.
   // ------------------------------------------------------------------
   always_comb begin
      req0_ready  = accept && !grant;
      req1_ready  = accept &&  grant;
      resp0_valid = (state == RESP) && !owner;
      resp1_valid = (state == RESP) &&  owner;
      resp0_rdata = resp0_valid ? rdata : 32'h0;
      resp1_rdata = resp1_valid ? rdata : 32'h0;
      busy        = (state != IDLE);

      nxt_idx   = 2'd0;
      nxt_we    = 1'b0;
      nxt_addr  = 7'h0;
      nxt_wdata = 8'h0;
      if (accept) begin
         nxt_idx   = 2'd3;
         nxt_we    = sel_req.we && sel_req.be[3];
         nxt_addr  = {sel_req.word, 2'd3};
         nxt_wdata = sel_req.wdata[31:24];
      end else if ((state == XFER) && (byte_idx != 2'd0)) begin
         nxt_idx   = byte_idx - 2'd1;
         // Disabled bytes still get their cycle, just without a strobe.
         nxt_we    = lat_req.we && lat_req.be[nxt_idx];
         nxt_addr  = {lat_req.word, nxt_idx};
         nxt_wdata = lat_req.wdata[8*nxt_idx +: 8];
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         byte_idx   <= 2'd0;
         lat_req    <= '0;
         rdata      <= 32'h0;
         reg_we     <= 1'b0;
         reg_addr   <= 7'h0;
         reg_wdata  <= 8'h0;
      end else begin
         byte_idx  <= nxt_idx;
         reg_we    <= nxt_we;
         reg_addr  <= nxt_addr;
         reg_wdata <= nxt_wdata;
         if (accept) begin
            last_grant <= grant;
            owner      <= grant;
            lat_req    <= sel_req;
            // Cleared here so a write completes with zero read data.
            rdata      <= 32'h0;
         end else if ((state == XFER) && !lat_req.we) begin
            // reg_rdata answers the byte address currently on the port.
            rdata[8*byte_idx +: 8] <= reg_rdata;
         end
      end
   end

   // Structural sanity: strobes only during a transfer, one response at a time.
   a_we_in_xfer : assert property (@(posedge clk) disable iff (rst)
                                   reg_we |-> (state == XFER));
   a_one_resp   : assert property (@(posedge clk) disable iff (rst)
                                   !(resp0_valid && resp1_valid));

endmodule

// File: tb/tb_sd_reg_seq_arbiter.sv
module tb_sd_reg_seq_arbiter;

   logic        clk;
   logic        rst;
   logic        req0_valid, req0_we, req0_ready, resp0_valid;
   logic [6:0]  req0_addr;
   logic [31:0] req0_wdata, resp0_rdata;
   logic [3:0]  req0_be;
   logic        req1_valid, req1_we, req1_ready, resp1_valid;
   logic [6:0]  req1_addr;
   logic [31:0] req1_wdata, resp1_rdata;
   logic [3:0]  req1_be;
   logic        reg_we;
   logic [6:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata;
   logic        busy;

   sd_reg_seq_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_ready(req0_ready),
      .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_ready(req1_ready),
      .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
      .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Register block: each byte initially holds its own address.
   logic [7:0] regs [128];
   bit regs_init = 0;
   assign reg_rdata = regs[reg_addr];
   always @(posedge clk) begin
      if (!regs_init) begin
         for (int i = 0; i < 128; i++) regs[i] <= 8'(i);
         regs_init <= 1'b1;
      end else if (reg_we) begin
         regs[reg_addr] <= reg_wdata;
      end
   end

   // Scoreboard queues
   typedef struct packed {
      logic [6:0] addr;
      logic       we;
      logic [7:0] wdata;
      logic [7:0] old;
   } bus_t;
   bus_t        bus_q[$];
   logic [31:0] resp0_q[$];
   logic [31:0] resp1_q[$];

   // Reference model: expected register contents, arbiter memory, word timing.
   logic [7:0] ref_mem [128];
   bit         mem_init = 0;
   int         cyc = 0;
   int         acc_cyc = -10;
   int         next_free = 0;
   logic       m_last = 1'b1;

   always @(negedge clk) begin : model
      bus_t        e;
      logic        g, v0, v1, er0, er1, eb, free, we;
      logic [6:0]  a, base, ba;
      logic [31:0] d, rd;
      logic [3:0]  be;
      cyc++;
      if (!mem_init) begin
         for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i);
         mem_init = 1'b1;
      end
      if (rst) begin
         // Abandoned transfer: bytes not yet issued never reach the registers.
         while (bus_q.size() > 0) begin
            e = bus_q.pop_front();
            if (e.we) ref_mem[e.addr] = e.old;
         end
         resp0_q.delete();
         resp1_q.delete();
         m_last = 1'b1;
         next_free = 0;
         acc_cyc = -10;
      end else begin
         v0 = req0_valid;
         v1 = req1_valid;
         free = (cyc >= next_free);
         g = (v0 && v1) ? ~m_last : ~v0;
         er0 = free && v0 && !g;
         er1 = free && v1 && g;
         eb = (cyc > acc_cyc) && (cyc < next_free);
         chk("req0_ready", 32'(req0_ready), 32'(er0));
         chk("req1_ready", 32'(req1_ready), 32'(er1));
         chk("busy", 32'(busy), 32'(eb));
         if (free && (v0 || v1)) begin
            we = g ? req1_we : req0_we;
            a  = g ? req1_addr : req0_addr;
            d  = g ? req1_wdata : req0_wdata;
            be = g ? req1_be : req0_be;
            base = {a[6:2], 2'b00};
            rd = 32'h0;
            for (int b = 3; b >= 0; b--) begin
               ba = base + 7'(b);
               e.addr  = ba;
               e.we    = we && be[b];
               e.wdata = d[8*b +: 8];
               e.old   = ref_mem[ba];
               if (!we) rd[8*b +: 8] = ref_mem[ba];
               if (e.we) ref_mem[ba] = e.wdata;
               bus_q.push_back(e);
            end
            if (g) resp1_q.push_back(rd);
            else   resp0_q.push_back(rd);
            m_last = g;
            acc_cyc = cyc;
            next_free = cyc + 6;
         end
      end
   end

   // Monitor: consumes expectations whenever the DUT presents a byte or a response.
   always @(negedge clk) begin : monitor
      bus_t e;
      if (!rst) begin
         if (busy && !resp0_valid && !resp1_valid) begin
            if (bus_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL bus_extra: byte cycle at addr %h, expected none", reg_addr);
            end else begin
               e = bus_q.pop_front();
               chk("reg_addr", 32'(reg_addr), 32'(e.addr));
               chk("reg_we", 32'(reg_we), 32'(e.we));
               chk("reg_wdata", 32'(reg_wdata), 32'(e.wdata));
            end
         end else begin
            chk("reg_port_idle", {16'h0, reg_we, reg_addr, reg_wdata}, 32'h0);
         end
         if (resp0_valid) begin
            if (resp0_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL resp0_extra: got pulse rdata %h, expected none", resp0_rdata);
            end else chk("resp0_rdata", resp0_rdata, resp0_q.pop_front());
         end
         if (resp1_valid) begin
            if (resp1_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL resp1_extra: got pulse rdata %h, expected none", resp1_rdata);
            end else chk("resp1_rdata", resp1_rdata, resp1_q.pop_front());
         end
      end
   end

   // Drive one request and hold it until the DUT takes it.
   task automatic issue(input int n, input logic we, input logic [6:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      int t = 0;
      if (n == 0) begin
         req0_we = we; req0_addr = a; req0_wdata = d; req0_be = be; req0_valid = 1'b1;
      end else begin
         req1_we = we; req1_addr = a; req1_wdata = d; req1_be = be; req1_valid = 1'b1;
      end
      forever begin
         @(negedge clk);
         if ((n == 0) ? req0_ready : req1_ready) break;
         t++;
         if (t > 200) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout req%0d: no accept in 200 cycles, expected accept", n);
            break;
         end
      end
      @(posedge clk); #1;
      if (n == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_reg_port"}, {16'h0, reg_we, reg_addr, reg_wdata}, 32'h0);
      chk({nm, "_busy"}, 32'(busy), 32'h0);
      chk({nm, "_ready"}, {30'h0, req1_ready, req0_ready}, 32'h0);
      chk({nm, "_resp_valid"}, {30'h0, resp1_valid, resp0_valid}, 32'h0);
      chk({nm, "_resp0_rdata"}, resp0_rdata, 32'h0);
      chk({nm, "_resp1_rdata"}, resp1_rdata, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 7'h0; req0_wdata = 32'h0; req0_be = 4'h0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 7'h0; req1_wdata = 32'h0; req1_be = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Write to argument register, then read of a fresh word.
      issue(0, 1'b1, 7'h00, 32'hDEADBEEF, 4'hF);
      issue(1, 1'b0, 7'h20, 32'h0, 4'h0);

      // Contention: grants must alternate.
      fork
         begin
            issue(0, 1'b1, 7'h08, 32'h01020304, 4'hF);
            issue(0, 1'b0, 7'h0C, 32'h0, 4'h0);
         end
         begin
            issue(1, 1'b1, 7'h0C, 32'hA0B0C0D0, 4'hF);
            issue(1, 1'b0, 7'h08, 32'h0, 4'h0);
         end
      join

      // Byte enables with byte 0 suppressed, then unaligned address.
      issue(0, 1'b1, 7'h04, 32'hA1B2C3D4, 4'b1110);
      issue(1, 1'b1, 7'h06, 32'h99887766, 4'hF);
      issue(0, 1'b0, 7'h05, 32'h12345678, 4'h0);

      // Random traffic from both requesters.
      fork
         for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
            issue(0, 1'($urandom_range(0, 1)), 7'($urandom), $urandom, 4'($urandom));
         end
         for (int j = 0; j < 25; j++) begin
            repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
            issue(1, 1'($urandom_range(0, 1)), 7'($urandom), $urandom, 4'($urandom));
         end
      join
      repeat (8) begin @(posedge clk); #1; end

      // Reset during the byte-1 cycle of a write.
      issue(0, 1'b1, 7'h10, 32'hCAFEF00D, 4'hF);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      fork
         issue(0, 1'b1, 7'h11, 32'h11223344, 4'hF);
         issue(1, 1'b1, 7'h40, 32'h55667788, 4'h3);
         begin
            #1;
            chk_all_zero("midreset");
            @(posedge clk);
            @(posedge clk); #1;
            rst = 1'b0;
         end
      join
      // Reads back the word hit by the reset (later rewritten by req0).
      issue(1, 1'b0, 7'h10, 32'h0, 4'h0);
      issue(0, 1'b0, 7'h40, 32'h0, 4'h0);

      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
      chk("resp0_q_drained", 32'(resp0_q.size()), 32'h0);
      chk("resp1_q_drained", 32'(resp1_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sd_reg_seq_arbiter.md
# sd_reg_seq_arbiter

Sequencer and arbiter for the SD controller's byte-wide register port (7-bit byte address, 8-bit write data, combinational 8-bit read data). It accepts 32-bit word read and write requests from two requesters, such as the host bridge and an autonomous command/init engine. It grants one requester at a time, round-robin, and serializes each word into four byte cycles. Bytes are issued from most significant to least significant, so byte 0 is always written last. This matters because byte-0 writes have side effects: writing byte 0 of the argument register starts a command, and writing byte 0 of an ISR register clears it. With this ordering, the full word is stable before the side effect fires.

## Interface
Parameters:
- None. Widths are fixed: 7-bit register address, 32-bit word, 8-bit register data.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- reqN_valid  in  1  request from requester N (N = 0, 1); held high until accepted.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  7  word address; bits [1:0] ignored.
- reqN_wdata  in  32  write data.
- reqN_be  in  4  byte enables for writes; ignored for reads.
- reqN_ready  out  1  accept strobe; the request is taken when valid && ready.
- respN_valid  out  1  one-cycle completion pulse.
- respN_rdata  out  32  read data; valid while respN_valid is high; 0 for writes.
- reg_we  out  1  byte write strobe to the register block.
- reg_addr  out  7  byte address to the register block.
- reg_wdata  out  8  byte write data.
- reg_rdata  in  8  combinational read byte for reg_addr.
- busy  out  1  high in XFER and RESP.

## Operation
- States: IDLE, XFER, RESP.
- IDLE:
  - grant = requester with valid; if both are valid, grant the requester not granted last (last_grant flop, reset = 1, so req0 wins first).
  - reqN_ready = (state == IDLE) && granted N, combinational.
  - On accept: latch we, addr[6:2], wdata, be, owner; byte_idx <= 3; go to XFER.
- XFER, one cycle per byte, byte_idx = 3, 2, 1, 0:
  - reg_addr = {addr[6:2], byte_idx}.
  - reg_wdata = wdata[8*byte_idx +: 8].
  - reg_we = we && be[byte_idx].
  - If the request is a read, rdata[8*byte_idx +: 8] <= reg_rdata at the end of the cycle.
  - Disabled bytes still consume their cycle, with reg_we = 0.
  - After byte_idx = 0, go to RESP.
- RESP: respOwner_valid = 1 and respOwner_rdata = rdata (0 for writes); return to IDLE. The owner can re-request in the next cycle.
- Outside XFER: reg_we = 0, reg_addr = 0, reg_wdata = 0.
- Requests not granted keep waiting; there is no starvation because of round-robin.
- A requester's valid deasserting while another transfer is in progress has no effect.

## Timing
- Accept in cycle T. Byte cycles in T+1..T+4 (byte 3 at T+1, byte 0 at T+4). resp_valid in T+5. Next accept possible at T+6.
- Throughput: 6 cycles per word. Write latency (accept to byte-0 strobe): 4 cycles.
- reg_we, reg_addr and reg_wdata are registered from state/byte_idx; no combinational path from reqN_* to reg_*.
- Reset, asserted at any time including mid-XFER: state = IDLE, last_grant = 1, byte_idx = 0, rdata = 0, all outputs 0. The in-flight request is abandoned; no resp pulse is issued. Bytes already written stay written.
- Simultaneous req0/req1 at the cycle reset deasserts: req0 is granted.

## Test plan
- Write to argument: req0 write, addr 0x00, wdata 0xDEADBEEF, be 4'hF. Expect reg_we on 4 consecutive cycles: (0x03, 0xDE), (0x02, 0xAD), (0x01, 0xBE), (0x00, 0xEF). Then resp0_valid 1 cycle later with rdata 0; busy high for 5 cycles.
- Read: req1 read, addr 0x20, with a register model returning the byte {1'b0, reg_addr}. Expect reg_addr sequence 0x23, 0x22, 0x21, 0x20; reg_we = 0 throughout; resp1_rdata = 0x23222120.
- Arbitration: req0 and req1 both held valid. Grants go req0, req1, req0, req1, with accepts 6 cycles apart and no lost responses.
- Byte enables: write with be 4'b1110 to addr 0x04. reg_we is high for addresses 0x07, 0x06, 0x05 and low in the 0x04 cycle, so no trigger side effect occurs.
- Address alignment: addr 0x06 (low bits set). Bytes are issued to 0x07, 0x06, 0x05, 0x04.
- Reset mid-transfer: assert rst asynchronously after byte 2. All outputs go to 0 immediately and no resp pulse occurs. After release, a pending req1 is accepted first only if req0 is idle; with both pending, req0 is accepted first.
